// File: rtl/gray_updown_pkg.sv
// Shared constants for the up/down Gray counter: default width and direction encodings.
package gray_updown_pkg;

    localparam int   GU_WIDTH_DEFAULT = 4;
    localparam logic DIR_UP           = 1'b1;
    localparam logic DIR_DOWN         = 1'b0;

endpackage

// File: rtl/gray_updown_gray2bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    always_comb begin
        o_bin = '0;
        o_bin[WIDTH-1] = i_gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            o_bin[i] = o_bin[i+1] ^ i_gray[i];
        end
    end

endmodule

// File: rtl/gray_updown.sv
// Up/down counter holding a binary count and a registered Gray image of it, with a Gray-coded
// parallel load, sticky overflow/underflow flags and a one-cycle wrap pulse.
module gray_updown
    import gray_updown_pkg::*;
#(
    parameter int WIDTH = GU_WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Dir,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             ClrFlag,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Binary,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_ovf;
    logic             r_unf;
    logic             r_wrap;

    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_bin_next;
    logic             w_up_wrap;
    logic             w_dn_wrap;

    gray2bin #(
        .WIDTH (WIDTH)
    ) u_gray2bin (
        .i_gray (LoadVal),
        .o_bin  (w_load_bin)
    );

    // Load beats counting; a load never produces a wrap.
    always_comb begin
        w_bin_next = r_bin;
        w_up_wrap  = 1'b0;
        w_dn_wrap  = 1'b0;
        if (Load) begin
            w_bin_next = w_load_bin;
        end else if (En) begin
            if (Dir == DIR_UP) begin
                w_bin_next = r_bin + 1'b1;
                w_up_wrap  = (r_bin == MAX_COUNT);
            end else begin
                w_bin_next = r_bin - 1'b1;
                w_dn_wrap  = (r_bin == '0);
            end
        end
    end

    // Gray image is registered alongside the count so Output never sees a decode path.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_bin_next ^ (w_bin_next >> 1);
            r_wrap <= w_up_wrap | w_dn_wrap;
            if (w_up_wrap) begin
                r_ovf <= 1'b1;
            end else if (ClrFlag) begin
                r_ovf <= 1'b0;
            end
            if (w_dn_wrap) begin
                r_unf <= 1'b1;
            end else if (ClrFlag) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign Output    = r_gray;
    assign Binary    = r_bin;
    assign Overflow  = r_ovf;
    assign Underflow = r_unf;
    assign Wrap      = r_wrap;

endmodule

// File: doc/gray_updown.md
GRAY_UPDOWN -- requirements
Module: gray_updown

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter width; legal range 2..16.
REQ-002 Port Clk, input, 1, SHALL be the sole clock; all state updates on its rising edge.
REQ-003 Port Reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-004 Port En, input, 1, SHALL enable counting by one step per cycle when high.
REQ-005 Port Dir, input, 1, SHALL select direction: 1 = up, 0 = down.
REQ-006 Port Load, input, 1, SHALL request a parallel load of LoadVal.
REQ-007 Port LoadVal, input, WIDTH, SHALL carry the value to load, Gray-coded.
REQ-008 Port ClrFlag, input, 1, SHALL clear the sticky flags.
REQ-009 Port Output, output, WIDTH, SHALL present the registered Gray code of the count.
REQ-010 Port Binary, output, WIDTH, SHALL present the registered binary count.
REQ-011 Port Overflow, output, 1, SHALL be a sticky flag for an up-wrap.
REQ-012 Port Underflow, output, 1, SHALL be a sticky flag for a down-wrap.
REQ-013 Port Wrap, output, 1, SHALL be a one-cycle pulse on any wrap.

Function
REQ-014 The block SHALL hold one WIDTH-bit binary count register B; Output SHALL equal B ^ (B >> 1) at all times, with no combinational path from inputs.
REQ-015 Per-edge priority SHALL be: Reset > Load > En count > hold.
REQ-016 When Load=1 and Reset=0, B SHALL take gray-to-binary(LoadVal) on the next edge, regardless of En.
REQ-017 On a load cycle, the flags SHALL NOT change except via ClrFlag, and Wrap SHALL be 0.
REQ-018 When En=1, Dir=1, and Load=0, B SHALL increment modulo 2^WIDTH.
REQ-019 When En=1, Dir=0, and Load=0, B SHALL decrement modulo 2^WIDTH.
REQ-020 When En=0 and Load=0, B SHALL hold, and Wrap SHALL be 0.
REQ-021 An up-step from B = 2^WIDTH-1 to 0 SHALL set Overflow and pulse Wrap in the same edge as the count change.
REQ-022 A down-step from B = 0 to 2^WIDTH-1 SHALL set Underflow and pulse Wrap in the same edge as the count change.
REQ-023 Wrap SHALL be high for exactly one cycle per wrap event and SHALL be 0 otherwise.
REQ-024 ClrFlag=1 SHALL clear Overflow and Underflow on the next edge.
REQ-025 If a wrap occurs in the same cycle as ClrFlag, setting the corresponding flag SHALL win.
REQ-026 ClrFlag SHALL NOT affect B or Wrap.
REQ-027 Dir MAY change on any cycle; each step SHALL use the Dir sampled at that edge.

Reset
REQ-028 Reset=1 SHALL force B=0 (Output=0, Binary=0), Overflow=0, Underflow=0, and Wrap=0 on the next edge, overriding Load, En, and ClrFlag.
REQ-029 Reset SHALL be honoured independent of En, including mid-count and mid-wrap.
REQ-030 No initial blocks SHALL be relied on for reset values.

Structure
REQ-031 A shared package/header SHALL hold the WIDTH default and the direction constants (UP=1, DOWN=0).
REQ-032 Gray-to-binary conversion SHALL be a combinational sub-module gray2bin, parameterised by WIDTH and instantiated once on the LoadVal path.
REQ-033 Binary-to-Gray conversion SHALL be inline.

Verification (WIDTH=3)
REQ-034 Reset, then En=1 and Dir=1 for 8 edges -> Output SHALL read 001,011,010,110,111,101,100,000; Overflow SHALL rise on edge 8; Wrap SHALL be high only after edge 8.
REQ-035 Reset, then En=1 and Dir=0 for 1 edge -> Output=100, Binary=111, Underflow=1, Overflow=0, Wrap pulse.
REQ-036 Load=1, LoadVal=110, En=1 -> next Binary=100 and Output=110 with no step; then Dir=1 for 1 edge -> Output=111.
REQ-037 B=111, Dir=1, En=1, ClrFlag=1 on the same edge -> Output=000 and Overflow=1 (set wins); ClrFlag alone on the next edge -> Overflow=0, B unchanged.
REQ-038 Count up to Output=101, then assert Reset together with Load=1 and En=1 -> all outputs SHALL be 0 on the next edge.
REQ-039 Alternate Dir every cycle with En=1 from B=0 -> B SHALL toggle 7,0,7,0; Underflow=1 and Overflow=1; Wrap high every cycle.
